// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: WB write-through bypass, load-use bubble insertion, flush/stall, bubble counter.
// Latency: 1 cycle ID -> EX; load_use_stall is combinational from current EX contents and ID specifiers.
// Backpressure: stall holds EX as-is; a load-use hazard asks upstream to hold via load_use_stall.
module id_ex_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clock_in,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [DATA_W-1:0]     id_readData1,
    input  logic [DATA_W-1:0]     id_readData2,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_usesRt,
    input  logic [DATA_W-1:0]     id_imm,
    input  logic                  id_regWrite,
    input  logic                  id_memRead,
    input  logic                  id_memWrite,
    input  logic                  id_memToReg,
    input  logic                  id_aluSrc,
    input  logic                  id_regDst,
    input  logic [3:0]            id_aluOp,
    input  logic                  wb_regWrite,
    input  logic [REG_ADDR_W-1:0] wb_writeReg,
    input  logic [DATA_W-1:0]     wb_writeData,
    output logic                  ex_valid,
    output logic [DATA_W-1:0]     ex_readData1,
    output logic [DATA_W-1:0]     ex_readData2,
    output logic [REG_ADDR_W-1:0] ex_rs,
    output logic [REG_ADDR_W-1:0] ex_rt,
    output logic [REG_ADDR_W-1:0] ex_writeReg,
    output logic [DATA_W-1:0]     ex_imm,
    output logic                  ex_regWrite,
    output logic                  ex_memRead,
    output logic                  ex_memWrite,
    output logic                  ex_memToReg,
    output logic                  ex_aluSrc,
    output logic [3:0]            ex_aluOp,
    output logic                  load_use_stall,
    output logic [CNT_W-1:0]      bubble_count
);

    typedef struct packed {
        logic                  valid;
        logic [DATA_W-1:0]     readData1;
        logic [DATA_W-1:0]     readData2;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] writeReg;
        logic [DATA_W-1:0]     imm;
        logic                  regWrite;
        logic                  memRead;
        logic                  memWrite;
        logic                  memToReg;
        logic                  aluSrc;
        logic [3:0]            aluOp;
    } exFields_t;

    exFields_t          exReg;
    exFields_t          idNext;
    logic [CNT_W-1:0]   bubbleCount;
    logic               hz;
    logic [DATA_W-1:0]  op1;
    logic [DATA_W-1:0]  op2;

    // The register file is written at the same edge we capture, so forward WB data here.
    always_comb begin
        op1 = id_readData1;
        op2 = id_readData2;
        if (id_rs == '0)
            op1 = '0;
        else if (wb_regWrite && (wb_writeReg == id_rs))
            op1 = wb_writeData;
        if (id_rt == '0)
            op2 = '0;
        else if (wb_regWrite && (wb_writeReg == id_rt))
            op2 = wb_writeData;
    end

    always_comb begin
        hz = id_valid && exReg.valid && exReg.memRead && (exReg.writeReg != '0) &&
             ((exReg.writeReg == id_rs) || (id_usesRt && (exReg.writeReg == id_rt)));
        load_use_stall = hz && !flush;
    end

    always_comb begin
        idNext           = '0;
        idNext.valid     = id_valid;
        idNext.readData1 = op1;
        idNext.readData2 = op2;
        idNext.rs        = id_rs;
        idNext.rt        = id_rt;
        idNext.writeReg  = id_regDst ? id_rd : id_rt;
        idNext.imm       = id_imm;
        idNext.regWrite  = id_regWrite && id_valid;
        idNext.memRead   = id_memRead  && id_valid;
        idNext.memWrite  = id_memWrite && id_valid;
        idNext.memToReg  = id_memToReg && id_valid;
        idNext.aluSrc    = id_aluSrc   && id_valid;
        idNext.aluOp     = id_valid ? id_aluOp : 4'h0;
    end

    // A bubble is the all-zero record: invalid, no control, cleared data.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            exReg       <= '0;
            bubbleCount <= '0;
        end else if (flush) begin
            exReg <= '0;
        end else if (stall) begin
            exReg <= exReg;
        end else if (hz) begin
            exReg <= '0;
            if (bubbleCount != {CNT_W{1'b1}})
                bubbleCount <= bubbleCount + 1'b1;
        end else begin
            exReg <= idNext;
        end
    end

    assign ex_valid     = exReg.valid;
    assign ex_readData1 = exReg.readData1;
    assign ex_readData2 = exReg.readData2;
    assign ex_rs        = exReg.rs;
    assign ex_rt        = exReg.rt;
    assign ex_writeReg  = exReg.writeReg;
    assign ex_imm       = exReg.imm;
    assign ex_regWrite  = exReg.regWrite;
    assign ex_memRead   = exReg.memRead;
    assign ex_memWrite  = exReg.memWrite;
    assign ex_memToReg  = exReg.memToReg;
    assign ex_aluSrc    = exReg.aluSrc;
    assign ex_aluOp     = exReg.aluOp;
    assign bubble_count = bubbleCount;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; a second instance with a narrow counter exercises saturation cheaply.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush, id_valid;
    logic [31:0] id_readData1, id_readData2, id_imm, wb_writeData;
    logic [4:0]  id_rs, id_rt, id_rd, wb_writeReg;
    logic        id_usesRt, id_regWrite, id_memRead, id_memWrite, id_memToReg, id_aluSrc, id_regDst;
    logic [3:0]  id_aluOp;
    logic        wb_regWrite;

    logic        ex_valid, ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg, ex_aluSrc, load_use_stall;
    logic [31:0] ex_readData1, ex_readData2, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_writeReg;
    logic [3:0]  ex_aluOp;
    logic [15:0] bubble_count;

    logic        s_valid, s_regWrite, s_memRead, s_memWrite, s_memToReg, s_aluSrc, s_stall;
    logic [31:0] s_rd1, s_rd2, s_imm;
    logic [4:0]  s_rs, s_rt, s_wr;
    logic [3:0]  s_aluOp;
    logic [3:0]  s_count;

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clock_in(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_readData1(id_readData1), .id_readData2(id_readData2),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_usesRt(id_usesRt), .id_imm(id_imm),
        .id_regWrite(id_regWrite), .id_memRead(id_memRead), .id_memWrite(id_memWrite),
        .id_memToReg(id_memToReg), .id_aluSrc(id_aluSrc), .id_regDst(id_regDst), .id_aluOp(id_aluOp),
        .wb_regWrite(wb_regWrite), .wb_writeReg(wb_writeReg), .wb_writeData(wb_writeData),
        .ex_valid(ex_valid), .ex_readData1(ex_readData1), .ex_readData2(ex_readData2),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_writeReg(ex_writeReg), .ex_imm(ex_imm),
        .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
        .ex_memToReg(ex_memToReg), .ex_aluSrc(ex_aluSrc), .ex_aluOp(ex_aluOp),
        .load_use_stall(load_use_stall), .bubble_count(bubble_count)
    );

    id_ex_stage #(.CNT_W(4)) dutSat (
        .clock_in(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_readData1(id_readData1), .id_readData2(id_readData2),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_usesRt(id_usesRt), .id_imm(id_imm),
        .id_regWrite(id_regWrite), .id_memRead(id_memRead), .id_memWrite(id_memWrite),
        .id_memToReg(id_memToReg), .id_aluSrc(id_aluSrc), .id_regDst(id_regDst), .id_aluOp(id_aluOp),
        .wb_regWrite(wb_regWrite), .wb_writeReg(wb_writeReg), .wb_writeData(wb_writeData),
        .ex_valid(s_valid), .ex_readData1(s_rd1), .ex_readData2(s_rd2),
        .ex_rs(s_rs), .ex_rt(s_rt), .ex_writeReg(s_wr), .ex_imm(s_imm),
        .ex_regWrite(s_regWrite), .ex_memRead(s_memRead), .ex_memWrite(s_memWrite),
        .ex_memToReg(s_memToReg), .ex_aluSrc(s_aluSrc), .ex_aluOp(s_aluOp),
        .load_use_stall(s_stall), .bubble_count(s_count)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present a load word: rt <- mem[rs + imm], destination rt.
    task automatic presentLoad(input logic [4:0] rs, input logic [4:0] rt);
        id_valid = 1'b1; id_rs = rs; id_rt = rt; id_rd = 5'd0; id_regDst = 1'b0;
        id_memRead = 1'b1; id_memToReg = 1'b1; id_regWrite = 1'b1; id_aluSrc = 1'b1;
        id_usesRt = 1'b0; id_aluOp = 4'h2; id_memWrite = 1'b0;
    endtask

    // Present an R-type: rd <- rs op rt.
    task automatic presentRType(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                input logic usesRt);
        id_valid = 1'b1; id_rs = rs; id_rt = rt; id_rd = rd; id_regDst = 1'b1;
        id_memRead = 1'b0; id_memToReg = 1'b0; id_regWrite = 1'b1; id_aluSrc = 1'b0;
        id_usesRt = usesRt; id_aluOp = 4'h2; id_memWrite = 1'b0;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
        id_readData1 = '0; id_readData2 = '0; id_imm = '0; id_rs = '0; id_rt = '0; id_rd = '0;
        id_usesRt = 1'b0; id_regWrite = 1'b0; id_memRead = 1'b0; id_memWrite = 1'b0;
        id_memToReg = 1'b0; id_aluSrc = 1'b0; id_regDst = 1'b0; id_aluOp = '0;
        wb_regWrite = 1'b0; wb_writeReg = '0; wb_writeData = '0;

        #42;
        checkVal("rst_valid", ex_valid, 0);
        checkVal("rst_count", bubble_count, 0);
        checkVal("rst_lus", load_use_stall, 0);
        checkVal("rst_wr", ex_writeReg, 0);
        reset = 1'b0;

        // Plain load of an R-type.
        presentRType(5'd1, 5'd2, 5'd3, 1'b1);
        id_readData1 = 32'd255; id_readData2 = 32'd7; id_imm = 32'h10; id_aluOp = 4'h6;
        tick;
        checkVal("ld_rd1", ex_readData1, 255);
        checkVal("ld_rd2", ex_readData2, 7);
        checkVal("ld_wr", ex_writeReg, 3);
        checkVal("ld_valid", ex_valid, 1);
        checkVal("ld_rs", ex_rs, 1);
        checkVal("ld_rt", ex_rt, 2);
        checkVal("ld_imm", ex_imm, 32'h10);
        checkVal("ld_aluop", ex_aluOp, 4'h6);
        checkVal("ld_regwr", ex_regWrite, 1);

        // WB write-through bypass on rt, then register 0 never bypassed.
        wb_regWrite = 1'b1; wb_writeReg = 5'd2; wb_writeData = 32'd233; id_readData2 = 32'd0;
        tick;
        checkVal("byp_rt", ex_readData2, 233);
        checkVal("byp_rs_nomatch", ex_readData1, 255);
        wb_writeReg = 5'd0; id_rt = 5'd0; id_readData2 = 32'd99;
        tick;
        checkVal("byp_r0", ex_readData2, 0);
        wb_writeReg = 5'd1; wb_writeData = 32'hCAFE;
        tick;
        checkVal("byp_rs", ex_readData1, 32'hCAFE);
        wb_regWrite = 1'b0;

        // id_valid low: data loads but control is gated off.
        id_valid = 1'b0;
        tick;
        checkVal("inv_valid", ex_valid, 0);
        checkVal("inv_regwr", ex_regWrite, 0);
        checkVal("inv_aluop", ex_aluOp, 0);

        // Load-use on rs.
        presentLoad(5'd1, 5'd5);
        tick;
        checkVal("lw_memrd", ex_memRead, 1);
        checkVal("lw_wr", ex_writeReg, 5);
        presentRType(5'd5, 5'd6, 5'd7, 1'b1);
        id_readData1 = 32'd11;
        #1;
        checkVal("lu_stall", load_use_stall, 1);
        tick;
        checkVal("lu_bub_valid", ex_valid, 0);
        checkVal("lu_bub_rd1", ex_readData1, 0);
        checkVal("lu_bub_memrd", ex_memRead, 0);
        checkVal("lu_count", bubble_count, 1);
        checkVal("lu_stall_off", load_use_stall, 0);
        tick;
        checkVal("lu_load_valid", ex_valid, 1);
        checkVal("lu_load_wr", ex_writeReg, 7);
        checkVal("lu_load_rd1", ex_readData1, 11);
        checkVal("lu_count_hold", bubble_count, 1);

        // rt match ignored when the instruction does not read rt.
        presentLoad(5'd1, 5'd5);
        tick;
        presentRType(5'd2, 5'd5, 5'd8, 1'b0);
        #1;
        checkVal("usesrt0_stall", load_use_stall, 0);
        tick;
        checkVal("usesrt0_wr", ex_writeReg, 8);
        checkVal("usesrt0_count", bubble_count, 1);

        // rt hazard with usesRt, then stall and flush priority.
        presentLoad(5'd1, 5'd5);
        tick;
        presentRType(5'd2, 5'd5, 5'd9, 1'b1);
        #1;
        checkVal("usesrt1_stall", load_use_stall, 1);
        stall = 1'b1;
        #1;
        checkVal("stall_lus", load_use_stall, 1);
        tick;
        checkVal("stall_wr", ex_writeReg, 5);
        checkVal("stall_memrd", ex_memRead, 1);
        checkVal("stall_count", bubble_count, 1);
        flush = 1'b1;
        #1;
        checkVal("flush_lus", load_use_stall, 0);
        tick;
        checkVal("flush_valid", ex_valid, 0);
        checkVal("flush_memrd", ex_memRead, 0);
        checkVal("flush_count", bubble_count, 1);
        flush = 1'b0; stall = 1'b0;

        // A self-dependent load alternates load / bubble: 20 bubbles over 40 edges.
        presentLoad(5'd5, 5'd5);
        for (int i = 0; i < 40; i++) tick;
        checkVal("sat_count", bubble_count, 21);
        checkVal("sat_narrow", s_count, 4'hF);

        // Async reset between edges clears immediately.
        tick;
        checkVal("pre_rst_valid", ex_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        checkVal("arst_valid", ex_valid, 0);
        checkVal("arst_wr", ex_writeReg, 0);
        checkVal("arst_memrd", ex_memRead, 0);
        checkVal("arst_count", bubble_count, 0);
        checkVal("arst_narrow", s_count, 0);
        checkVal("arst_lus", load_use_stall, 0);
        reset = 1'b0;
        tick;
        checkVal("post_rst_valid", ex_valid, 1);
        checkVal("post_rst_wr", ex_writeReg, 5);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage MIPS core; sits directly downstream of the Register file.
- Latches the file's readData1/readData2, the decoded register specifiers, the immediate and the control bits for the EX stage.
- Adds a WB-to-ID write-through bypass, load-use hazard detection with self-inserted bubbles, flush/stall control and a saturating bubble counter.

Parameters:
- DATA_W, 32, datapath width
- REG_ADDR_W, 5, register specifier width
- CNT_W, 16, bubble counter width

Ports:
- clock_in  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- stall  in  1  downstream hold; EX register keeps its contents
- flush  in  1  branch/jump squash; next EX contents become a bubble
- id_valid  in  1  ID slot holds a real instruction
- id_readData1  in  DATA_W  Register file port 1 data (rs)
- id_readData2  in  DATA_W  Register file port 2 data (rt)
- id_rs, id_rt, id_rd  in  REG_ADDR_W  decoded specifiers
- id_usesRt  in  1  instruction reads rt as a source
- id_imm  in  DATA_W  sign-extended immediate
- id_regWrite, id_memRead, id_memWrite, id_memToReg, id_aluSrc, id_regDst  in  1 each  control bits
- id_aluOp  in  4  ALU operation
- wb_regWrite  in  1  WB-stage write enable (same signal driving the file's regWrite)
- wb_writeReg  in  REG_ADDR_W  WB destination
- wb_writeData  in  DATA_W  WB data
- ex_valid  out  1  EX slot valid
- ex_readData1, ex_readData2  out  DATA_W  latched operands
- ex_rs, ex_rt  out  REG_ADDR_W  latched specifiers (for the forwarding unit)
- ex_writeReg  out  REG_ADDR_W  destination: id_rd if id_regDst else id_rt
- ex_imm  out  DATA_W  latched immediate
- ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg, ex_aluSrc  out  1 each  latched control
- ex_aluOp  out  4  latched ALU op
- load_use_stall  out  1  combinational request to hold PC and IF/ID
- bubble_count  out  CNT_W  number of hazard bubbles inserted

Behaviour:
- Reset (async, immediate):
  - All outputs 0; EX holds a bubble; bubble_count = 0; load_use_stall evaluates to 0.
- Hazard (combinational):
  - hz = id_valid & ex_valid & ex_memRead & (ex_writeReg != 0) & ((ex_writeReg == id_rs) | (id_usesRt & ex_writeReg == id_rt)).
  - load_use_stall = hz & ~flush.
- Bypass on captured operands:
  - op1 = 0 if id_rs == 0; else wb_writeData if wb_regWrite & wb_writeReg == id_rs; else id_readData1.
  - op2 is the same rule using id_rt and id_readData2.
- Per-edge action, first match wins:
  1. flush: load a bubble. Flush overrides stall and hazard.
  2. stall: hold all EX fields unchanged. No bubble is inserted and no counter increment.
  3. hz: load a bubble and increment bubble_count. The counter saturates at all-ones.
  4. Otherwise: load the ID fields. ex_valid = id_valid. Control bits are gated by id_valid, so id_valid = 0 loads control = 0.
- Bubble definition:
  - ex_valid = 0; all control bits and ex_aluOp = 0.
  - Data and specifier fields cleared to 0, giving deterministic waveforms.
- Timing:
  - Latency is 1 cycle from ID inputs to EX outputs.
  - A hazard inserts exactly one bubble: on the next cycle EX holds that bubble (ex_valid = 0), so hz deasserts and the held instruction is loaded.
- Reset asserted mid-operation clears immediately, regardless of stall or flush. The first edge after deassert follows the normal rules.
- Register 0 is never bypassed and never triggers a hazard.

Test Plan:
- Reset then load: assert reset for 40 ns, then id_valid = 1, id_rs = 1, id_rt = 2, id_readData1 = 255, id_readData2 = 7, id_regDst = 1, id_rd = 3 → after 1 edge: ex_readData1 = 255, ex_readData2 = 7, ex_writeReg = 3, ex_valid = 1.
- Bypass: wb_regWrite = 1, wb_writeReg = 2, wb_writeData = 233, id_rt = 2, id_readData2 = 0 → ex_readData2 = 233. Repeat with wb_writeReg = 0 and id_rt = 0 → ex_readData2 = 0.
- Load-use: EX holds a lw with ex_writeReg = 5; ID presents id_rs = 5 → load_use_stall = 1, next edge ex_valid = 0 and bubble_count = 1, following edge loads the ID instruction.
- id_usesRt gating: same as the load-use case but the match is on id_rt with id_usesRt = 0 → no stall, bubble_count unchanged.
- Priority: stall = 1 with a hazard present → EX unchanged, count unchanged. flush = 1 together with stall and hazard → bubble, load_use_stall = 0, count unchanged.
- Saturation and async reset: force 65 536 or more hazard bubbles → bubble_count stays 0xFFFF. Pulse reset between clock edges → all outputs 0 immediately.
